uart_tx_arbiter: RTL

- Shares one UART transmitter among NUM_REQ byte requesters using round-robin arbitration.
- Latches the granted requester's byte and issues a single start strobe to the transmitter.
- Waits for the transmitter's completion pulse, with a watchdog timeout, then returns completion to that requester.
- Sits between the system's byte producers and the UART TX block; mirrors the UART_RX side of the link.

---
 rtl/uart_tx_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte
// requesters, with a watchdog on the transmitter's completion pulse.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 20000,
  parameter int IDX_W   = 2
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]     ack_o,
  output logic [NUM_REQ-1:0]     done_o,
  output logic [7:0]             tx_data_o,
  output logic                   tx_ready_o,
  input  logic                   tx_done_i,
  output logic                   busy_o,
  output logic [IDX_W-1:0]       owner_o,
  output logic                   timeout_err_o,
  input  logic                   err_clear_i
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    RELEASE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             err_q, err_d;

  logic             wd_expired;
  logic             timeout_hit;
  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;
  logic [7:0]       owner_byte;

  assign wd_expired  = (wd_q == WD_MAX);
  // tx_done takes priority over an expiring watchdog in the same cycle
  assign timeout_hit = (state_q == WAIT) && !tx_done_i && wd_expired;

  // First pending requester at or after the round-robin pointer
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    owner_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_byte = req_data_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req_i) state_d = LOAD;
      LOAD:    state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (tx_done_i || wd_expired) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_o      = '0;
    done_o     = '0;
    tx_ready_o = 1'b0;
    busy_o     = (state_q != IDLE);
    unique case (state_q)
      LOAD:    ack_o      = NUM_REQ'(1) << owner_q;
      START:   tx_ready_o = 1'b1;
      RELEASE: done_o     = NUM_REQ'(1) << owner_q;
      default: ;
    endcase
  end

  always_comb begin
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    tx_data_d = tx_data_q;
    wd_d      = wd_q;
    err_d     = err_q;
    if (state_q == IDLE && grant_found) begin
      owner_d = grant_idx;
    end
    if (state_q == LOAD) begin
      tx_data_d = owner_byte;
    end
    if (state_q == START) begin
      wd_d = '0;
    end else if (state_q == WAIT && !tx_done_i && !wd_expired) begin
      wd_d = wd_q + 1'b1;
    end
    if (state_q == RELEASE) begin
      ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
    end
    // A timeout in the same cycle as err_clear leaves the flag set
    if (timeout_hit) begin
      err_d = 1'b1;
    end else if (err_clear_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      owner_q   <= '0;
      ptr_q     <= '0;
      tx_data_q <= '0;
      wd_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      tx_data_q <= tx_data_d;
      wd_q      <= wd_d;
      err_q     <= err_d;
    end
  end

  assign tx_data_o     = tx_data_q;
  assign owner_o       = owner_q;
  assign timeout_err_o = err_q;

endmodule
